// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a CLKS_PER_BIT baud timer.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data
// bits and the stop bit. The port list is the same in both builds.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       tx_arst,
  input  logic       tx_en,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // The last count of a bit period. The count one before it is used to
  // raise done, so that done is already high during the last STOP cycle.
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] DONE_AT   = 16'(CLKS_PER_BIT - 2);

  state_t      state, state_next;
  logic [15:0] baud_cnt, baud_next;
  logic [2:0]  bit_idx, idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic        tx_next, busy_next, done_next;
  logic        bit_end;
`ifdef UART_TX_PARITY_EN
  logic        parity_bit, parity_next;
`endif

  assign bit_end = (baud_cnt == BAUD_LAST);

  // Next-state and next-output decode. tx, busy and done are computed one
  // cycle ahead here, so the flops below drive the ports directly.
  always_comb begin
    // NOTE: every signal written in this block gets a default first. If
    // some branch left one unassigned, a latch would be inferred.
    state_next  = state;
    baud_next   = bit_end ? 16'd0 : baud_cnt + 16'd1;
    idx_next    = bit_idx;
    shift_next  = shift_reg;
    tx_next     = tx;
    busy_next   = busy;
    done_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_bit;
`endif

    case (state)
      IDLE: begin
        baud_next = 16'd0;
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (tx_en && tx_start) begin
          state_next  = START;
          shift_next  = data_in;
          idx_next    = 3'd0;
          tx_next     = 1'b0;
          busy_next   = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_next = ^data_in;
`endif
        end
      end

      START: begin
        if (bit_end) begin
          state_next = DATA;
          tx_next    = shift_reg[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = parity_bit;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            // The bit now on the line is shift_reg[0]. Shift right and put
            // the next bit on the line.
            idx_next   = bit_idx + 3'd1;
            shift_next = {1'b0, shift_reg[7:1]};
            tx_next    = shift_reg[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
`endif

      STOP: begin
        done_next = (baud_cnt == DONE_AT);
        if (bit_end) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers. Reset clears all of them at once.
  always_ff @(posedge clk or posedge tx_arst) begin
    if (tx_arst) begin
      // NOTE: the shift register is cleared on reset like the control
      // flops, so that nothing from an aborted frame survives reset.
      state      <= IDLE;
      baud_cnt   <= 16'd0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'd0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      // NOTE: use non-blocking assignments here. Every flop then samples
      // the values from before this edge, so the order of lines does not
      // matter.
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_idx    <= idx_next;
      shift_reg  <= shift_next;
      tx         <= tx_next;
      busy       <= busy_next;
      done       <= done_next;
`ifdef UART_TX_PARITY_EN
      parity_bit <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with CLKS_PER_BIT=4.
// Each expected line pattern is written by hand as {stop, d7..d0, start}.
// An expected parity bit is also given for the UART_TX_PARITY_EN build.
module tb_uart_tx;

  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = N * FRAME_BITS;

  logic       clk = 1'b0;
  logic       tx_arst;
  logic       tx_en;
  logic       tx_start;
  logic [7:0] data_in;
  logic       tx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk      (clk),
    .tx_arst  (tx_arst),
    .tx_en    (tx_en),
    .tx_start (tx_start),
    .data_in  (data_in),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns the expected line level for bit slot j of the frame.
  function automatic logic line_bit(input logic [9:0] line, input logic par, input int j);
    if (FRAME_BITS == 11 && j == 9) return par;
    if (j >= 9) return 1'b1;
    return line[j];
  endfunction

  // Checks line, busy and done once per cycle for ncyc cycles.
  // Call it at the sample point just after the accepting edge, which is k=1.
  // At cycle poke_k it drives new input values. It returns at the sample
  // point for k = ncyc+1.
  task automatic watch_frame(input string tag, input logic [9:0] line, input logic par,
                             input int ncyc, input int poke_k, input logic p_en,
                             input logic p_start, input logic [7:0] p_data);
    for (int k = 1; k <= ncyc; k++) begin
      check($sformatf("%s tx k=%0d", tag, k), 16'(tx), 16'(line_bit(line, par, (k - 1) / N)));
      check($sformatf("%s busy k=%0d", tag, k), 16'(busy), 16'd1);
      check($sformatf("%s done k=%0d", tag, k), 16'(done), 16'(k == FRAME));
      if (k == poke_k) begin
        tx_en    = p_en;
        tx_start = p_start;
        data_in  = p_data;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s tx i=%0d", tag, i), 16'(tx), 16'd1);
      check($sformatf("%s busy i=%0d", tag, i), 16'(busy), 16'd0);
      check($sformatf("%s done i=%0d", tag, i), 16'(done), 16'd0);
      @(negedge clk);
    end
  endtask

  // Raises a request at a negedge while the transmitter is idle. The next
  // posedge accepts it. Returns at the k=1 sample point of the new frame.
  task automatic launch(input logic [7:0] d, input logic hold);
    check("launch idle tx", 16'(tx), 16'd1);
    check("launch idle busy", 16'(busy), 16'd0);
    data_in  = d;
    tx_en    = 1'b1;
    tx_start = 1'b1;
    @(negedge clk);
    if (!hold) tx_start = 1'b0;
  endtask

  initial begin
    tx_arst  = 1'b1;
    tx_en    = 1'b0;
    tx_start = 1'b0;
    data_in  = 8'h00;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst tx", 16'(tx), 16'd1);
    check("rst busy", 16'(busy), 16'd0);
    check("rst done", 16'(done), 16'd0);
    tx_arst = 1'b0;
    @(negedge clk);

    // A request with tx_en low is never accepted.
    tx_start = 1'b1;
    data_in  = 8'hA5;
    idle_cycles("en_low", 20);
    tx_start = 1'b0;

    // Send 0xA5. The line carries 1,0,1,0,0,1,0,1 LSB first.
    launch(8'hA5, 1'b0);
    watch_frame("a5", 10'b1101001010, 1'b0, FRAME, 0, 1'b1, 1'b0, 8'hA5);
    idle_cycles("a5 after", 3);

    // Send 0x3C. A second request with 0xFF arrives mid-frame and is ignored.
    launch(8'h3C, 1'b0);
    watch_frame("3c", 10'b1001111000, 1'b0, FRAME, 10, 1'b1, 1'b1, 8'hFF);
    tx_start = 1'b0;
    idle_cycles("3c no queue", 5);

    // Back-to-back 0x00 then 0xFF with tx_start held high.
    launch(8'h00, 1'b1);
    watch_frame("b2b 00", 10'b1000000000, 1'b0, FRAME, 20, 1'b1, 1'b1, 8'hFF);
    check("b2b gap tx", 16'(tx), 16'd1);
    check("b2b gap busy", 16'(busy), 16'd0);
    check("b2b gap done", 16'(done), 16'd0);
    @(negedge clk);
    tx_start = 1'b0;
    watch_frame("b2b ff", 10'b1111111110, 1'b0, FRAME, 0, 1'b1, 1'b0, 8'hFF);
    idle_cycles("b2b after", 2);

    // Reset during DATA bit 3 of 0xF0, whose bit 3 puts the line low.
    launch(8'hF0, 1'b0);
    watch_frame("f0", 10'b1111100000, 1'b0, 17, 0, 1'b1, 1'b0, 8'hF0);
    check("f0 bit3 before rst", 16'(tx), 16'd0);
    #2 tx_arst = 1'b1;
    #1;
    check("async rst tx", 16'(tx), 16'd1);
    check("async rst busy", 16'(busy), 16'd0);
    check("async rst done", 16'(done), 16'd0);
    @(negedge clk);
    check("rst held done", 16'(done), 16'd0);
    @(negedge clk);
    tx_arst = 1'b0;
    idle_cycles("post rst", 3);
    launch(8'h55, 1'b0);
    watch_frame("55", 10'b1010101010, 1'b0, FRAME, 0, 1'b1, 1'b0, 8'h55);
    idle_cycles("55 after", 2);

    // tx_en falls mid-frame. The frame completes and nothing new starts
    // until tx_en returns.
    launch(8'h81, 1'b1);
    watch_frame("81", 10'b1100000010, 1'b0, FRAME, 5, 1'b0, 1'b1, 8'h81);
    idle_cycles("en dropped", 10);
    tx_en = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    watch_frame("81 again", 10'b1100000010, 1'b0, FRAME, 0, 1'b1, 1'b0, 8'h81);
    idle_cycles("81 after", 2);

    // Parity frames: 0x07 gives parity 1 and 0x03 gives parity 0.
    launch(8'h07, 1'b0);
    watch_frame("07", 10'b1000001110, 1'b1, FRAME, 0, 1'b1, 1'b0, 8'h07);
    idle_cycles("07 after", 1);
    launch(8'h03, 1'b0);
    watch_frame("03", 10'b1000000110, 1'b0, FRAME, 0, 1'b1, 1'b0, 8'h03);
    idle_cycles("03 after", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, meaning clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single clock; all flops rising-edge.
REQ-003 SHALL have port tx_arst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port tx_en  input  1  enable; low blocks acceptance of new frames.
REQ-005 SHALL have port tx_start  input  1  request to send data_in; sampled only in IDLE.
REQ-006 SHALL have port data_in  input  8  byte to send; captured on acceptance.
REQ-007 SHALL have port tx  output  1  serial line, idle high.
REQ-008 SHALL have port busy  output  1  high from acceptance until the end of the stop bit.
REQ-009 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP; tx, busy and done SHALL be registered.
REQ-011 Acceptance SHALL occur on a clk edge in IDLE when tx_en=1 and tx_start=1; data_in SHALL be latched into a shift register on that edge.
REQ-012 Latency: tx SHALL go low and busy high on the cycle after the accepting edge (state START).
REQ-013 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by an internal baud counter that clears on every bit boundary and on acceptance.
REQ-014 DATA SHALL transmit 8 bits LSB first, using a 3-bit index that goes 0..7 and then exits to PARITY or STOP; the index SHALL NOT wrap.
REQ-015 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles; on its last cycle done SHALL pulse high for exactly 1 cycle, and busy SHALL fall together with the return to IDLE.
REQ-016 Frame length SHALL be 10*CLKS_PER_BIT cycles without the macro and 11*CLKS_PER_BIT with it.
REQ-017 tx_start while busy SHALL be ignored: no queueing, and latched data is unchanged.
REQ-018 data_in changes after acceptance SHALL NOT affect the frame in flight.
REQ-019 If tx_en falls mid-frame, the current frame SHALL complete; no new frame is accepted until tx_en=1.
REQ-020 Back-to-back: tx_start held high with tx_en=1 SHALL start the next frame on the cycle after done, leaving one idle cycle (tx=1) between the stop bit and the next start bit.

Reset
REQ-021 tx_arst=1 SHALL immediately, without a clock, force state IDLE, tx=1, busy=0, done=0, baud counter=0, bit index=0 and shift register=0.
REQ-022 Reset mid-frame SHALL abort the frame with no done pulse; after release the first frame SHALL begin no earlier than the first clk edge with tx_arst=0.

Configuration
REQ-023 Macro UART_TX_PARITY_EN: when defined, a PARITY state SHALL be inserted after DATA that sends the even-parity bit (XOR of the 8 latched data bits) for CLKS_PER_BIT cycles.
REQ-024 Without UART_TX_PARITY_EN, the PARITY state and parity logic SHALL be absent, and the ports SHALL be identical in both builds.

Verification (CLKS_PER_BIT=4)
REQ-025 Reset then idle: tx_arst pulse -> tx=1, busy=0, done=0; tx_start=1 with tx_en=0 for 20 cycles -> tx stays 1.
REQ-026 Send 0xA5: tx_start pulse -> one cycle later tx=0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1; done pulses at cycle 40 after acceptance; busy high for 40 cycles.
REQ-027 Ignore while busy: send 0x3C, assert tx_start with data_in=0xFF mid-frame -> line carries 0x3C only, with exactly one done pulse.
REQ-028 Back-to-back 0x00 then 0xFF with tx_start held -> two frames separated by one idle cycle, two done pulses 41 cycles apart.
REQ-029 Reset mid-frame: assert tx_arst during DATA bit 3 -> tx=1 the same cycle, no done pulse, and a subsequent 0x55 frame is correct.
REQ-030 With UART_TX_PARITY_EN: 0x07 -> parity bit 1, 0x03 -> parity bit 0; frames are 44 cycles long.
